game_timer: RTL and testbench
=============================

GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter TICK_DIV, default 27'd67108864: clock cycles per timer tick (one "minute" of game time); legal range 2..2^27.
REQ-002 Parameter MIN_LIMIT, default 8'd60: minutes value at which the game clock expires; legal range 1..255.
REQ-003 Parameter QUIZ_LEN, default 4'd5: ticks allowed per quiz before expiry; legal range 1..15.
REQ-004 Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  reset; asynchronous, active-low.
REQ-006 clear  input  1  synchronous clear, level (driven from q_INI).
REQ-007 start  input  1  single-cycle start pulse (debounced BtnC pulse).
REQ-008 pause  input  1  level; high while a quiz is active (driven from q_QUIZ).
REQ-009 freeze  input  1  level; high on win/lose (driven from q_WIN | q_LOSE).
REQ-010 minutes  output  8  elapsed minutes; feeds the fpsr minutes input and the SSD digits.
REQ-011 tick  output  1  one-cycle pulse per elapsed tick.
REQ-012 quiz_left  output  4  ticks remaining in the current quiz.
REQ-013 quiz_expired  output  1  one-cycle pulse when quiz_left reaches 0.
REQ-014 timeout  output  1  level; high when minutes == MIN_LIMIT.
REQ-015 running, paused, done  output  1 each  one-hot state flags for RUN, PAUSE and DONE; all low in IDLE.

Function
REQ-016 The state machine SHALL have four states: IDLE, RUN, PAUSE, DONE; it is held in IDLE by reset.
REQ-017 Prescaler: 27-bit counter that counts 0..TICK_DIV-1 and wraps in RUN and PAUSE; held at 0 in IDLE and DONE; not cleared on RUN<->PAUSE transitions.
REQ-018 tick SHALL be high in exactly the cycles where state is RUN or PAUSE and prescaler == TICK_DIV-1; it is decoded combinationally from registers.
REQ-019 Transition priority per edge: clear, then freeze, then the state-specific rules.
REQ-020 clear=1 in any state: next state IDLE; minutes, prescaler and quiz_left all go to 0.
REQ-021 freeze=1 (clear=0) in any non-IDLE state: next state DONE; a tick in the same cycle is discarded, so minutes does not increment.
REQ-022 IDLE: start=1 -> RUN. start is ignored in every other state.
REQ-023 RUN: on tick, minutes <= minutes+1.
REQ-024 RUN: if that increment makes minutes equal MIN_LIMIT, next state is DONE; this takes priority over pause.
REQ-025 RUN: otherwise, if pause=1, next state is PAUSE and quiz_left <= QUIZ_LEN; a tick in the same cycle still increments minutes.
REQ-026 PAUSE: minutes is held.
REQ-027 PAUSE: on tick with quiz_left > 0, quiz_left decrements by 1.
REQ-028 PAUSE: on tick with quiz_left == 1, quiz_expired pulses high for the following cycle only.
REQ-029 PAUSE: quiz_left holds at 0 with no further pulses.
REQ-030 PAUSE: pause=0 -> RUN, and quiz_left <= 0.
REQ-031 DONE: all counters hold; only clear leaves DONE.
REQ-032 minutes SHALL never exceed MIN_LIMIT and never wrap past 255.
REQ-033 Latency: minutes, quiz_left and the state flags update on the Clk edge that ends the tick cycle, i.e. one cycle after tick is high.
REQ-034 quiz_expired SHALL be registered.
REQ-035 timeout SHALL be decoded from the minutes register.

Reset
REQ-036 Reset_n low SHALL immediately, with no clock edge required, force IDLE.
REQ-037 Reset_n low SHALL force minutes=0, prescaler=0 and quiz_left=0.
REQ-038 Reset_n low SHALL force tick, quiz_expired and timeout low.
REQ-039 Reset_n low SHALL force running=0, paused=0 and done=0.
REQ-040 Reset asserted mid-operation SHALL abort any state; after release the block waits in IDLE for start.

Verification
REQ-041 (TICK_DIV=4, MIN_LIMIT=3) start pulse at cycle 0 -> running=1 from cycle 1; tick at cycles 4, 8 and 12; minutes reads 1, 2, 3 at cycles 5, 9, 13; at cycle 13 done=1, timeout=1, and tick stays low thereafter.
REQ-042 (TICK_DIV=4, QUIZ_LEN=2) pause raised during RUN -> paused=1 and quiz_left=2; after 2 ticks quiz_left=0 and quiz_expired is high for exactly 1 cycle; minutes is unchanged throughout.
REQ-043 pause raised in the same cycle as a RUN tick with minutes=4 -> minutes=5 and paused=1 on the next cycle; dropping pause -> running=1 and quiz_left=0.
REQ-044 freeze in the same cycle as a tick with minutes=2 -> done=1 with minutes still 2; then clear=1 -> IDLE with minutes=0.
REQ-045 Reset_n pulsed low asynchronously mid-PAUSE with minutes=7 -> all outputs 0 before the next Clk edge; start is required to run again.
REQ-046 start asserted in RUN, PAUSE or DONE -> no state or counter change.

Source files
------------

// File: rtl/game_timer.sv
// Game clock: a prescaler turns Clk into minute ticks, which advance a minute counter.
// While a quiz is open, the same ticks count down a quiz budget instead.
module game_timer #(
    parameter int unsigned TICK_DIV  = 67108864,
    parameter int unsigned MIN_LIMIT = 60,
    parameter int unsigned QUIZ_LEN  = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       clear,
    input  logic       start,
    input  logic       pause,
    input  logic       freeze,
    output logic [7:0] minutes,
    output logic       tick,
    output logic [3:0] quiz_left,
    output logic       quiz_expired,
    output logic       timeout,
    output logic       running,
    output logic       paused,
    output logic       done
);

    localparam logic [26:0] PRE_LAST  = 27'(TICK_DIV - 1);
    localparam logic [7:0]  MIN_LAST  = 8'(MIN_LIMIT);
    localparam logic [3:0]  QUIZ_INIT = 4'(QUIZ_LEN);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_e;

    state_e      state_q, state_d;
    logic [26:0] prescaler_q, prescaler_d;
    logic [7:0]  minutes_q, minutes_d;
    logic [3:0]  quizLeft_q, quizLeft_d;
    logic        quizExpired_q, quizExpired_d;
    logic [7:0]  minutesInc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q       <= IDLE;
            prescaler_q   <= '0;
            minutes_q     <= '0;
            quizLeft_q    <= '0;
            quizExpired_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prescaler_q   <= prescaler_d;
            minutes_q     <= minutes_d;
            quizLeft_q    <= quizLeft_d;
            quizExpired_q <= quizExpired_d;
        end
    end

    assign tick       = ((state_q == RUN) || (state_q == PAUSE)) && (prescaler_q == PRE_LAST);
    assign minutesInc = minutes_q + 8'd1;

    always_comb begin
        state_d       = state_q;
        prescaler_d   = prescaler_q;
        minutes_d     = minutes_q;
        quizLeft_d    = quizLeft_q;
        quizExpired_d = 1'b0;

        // The prescaler keeps its phase across RUN<->PAUSE, so a quiz does not shift the minute grid.
        if ((state_q == RUN) || (state_q == PAUSE)) begin
            prescaler_d = tick ? 27'd0 : prescaler_q + 27'd1;
        end

        if (clear) begin
            state_d     = IDLE;
            prescaler_d = '0;
            minutes_d   = '0;
            quizLeft_d  = '0;
        end else if (freeze && (state_q != IDLE)) begin
            state_d     = DONE;
            prescaler_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    prescaler_d = '0;
                    if (start) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        minutes_d = minutesInc;
                    end
                    if (tick && (minutesInc == MIN_LAST)) begin
                        state_d     = DONE;
                        prescaler_d = '0;
                    end else if (pause) begin
                        state_d    = PAUSE;
                        quizLeft_d = QUIZ_INIT;
                    end
                end
                PAUSE: begin
                    if (tick && (quizLeft_q != 4'd0)) begin
                        quizLeft_d    = quizLeft_q - 4'd1;
                        quizExpired_d = (quizLeft_q == 4'd1);
                    end
                    if (!pause) begin
                        state_d    = RUN;
                        quizLeft_d = '0;
                    end
                end
                DONE: begin
                    prescaler_d = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign minutes      = minutes_q;
    assign quiz_left    = quizLeft_q;
    assign quiz_expired = quizExpired_q;
    assign timeout      = (minutes_q == MIN_LAST);
    assign running      = (state_q == RUN);
    assign paused       = (state_q == PAUSE);
    assign done         = (state_q == DONE);

endmodule

// File: tb/tb_game_timer.sv
// Scoreboard bench for game_timer: expected output vectors are queued per cycle
// and popped as the DUT advances. Vector order: minutes,tick,quiz_left,quiz_expired,timeout,running,paused,done.
module tb_game_timer;

    localparam int TDIV = 4;
    localparam int MLIM = 10;
    localparam int QLEN = 2;

    logic       Clk = 1'b0;
    logic       Reset_n, clear, start, pause, freeze;
    logic [7:0] minutes;
    logic       tick;
    logic [3:0] quiz_left;
    logic       quiz_expired, timeout, running, paused, done;

    typedef struct {
        string      name;
        int         cyc;
        logic [17:0] v;
    } expT;

    expT expQ[$];
    int  errors = 0;
    int  checks = 0;

    game_timer #(.TICK_DIV(TDIV), .MIN_LIMIT(MLIM), .QUIZ_LEN(QLEN)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .clear(clear), .start(start),
        .pause(pause), .freeze(freeze), .minutes(minutes), .tick(tick),
        .quiz_left(quiz_left), .quiz_expired(quiz_expired), .timeout(timeout),
        .running(running), .paused(paused), .done(done)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [17:0] obsVec();
        return {minutes, tick, quiz_left, quiz_expired, timeout, running, paused, done};
    endfunction

    function automatic logic [17:0] mk(int m, bit t, int q, bit e, bit to, bit r, bit p, bit d);
        return {8'(m), t, 4'(q), e, to, r, p, d};
    endfunction

    function automatic void pushExp(string name, int cyc, logic [17:0] v);
        expT e;
        e.name = name;
        e.cyc  = cyc;
        e.v    = v;
        expQ.push_back(e);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyReset();
        Reset_n = 1'b0;
        clear = 1'b0; start = 1'b0; pause = 1'b0; freeze = 1'b0;
        step();
        step();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        expT e;
        Reset_n = 1'b0;
        clear = 1'b0; start = 1'b0; pause = 1'b0; freeze = 1'b0;
        #1;
        pushExp("reset_state", 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
        e = expQ.pop_front();
        checks++;
        if (obsVec() !== e.v) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
        end
    endtask

    // Run to MIN_LIMIT; start pulsed while DONE must be ignored.
    task automatic test_expiry();
        expT e;
        bit  dn;
        int  m;
        applyReset();
        start = 1'b1;
        for (int c = 1; c <= 46; c++) begin
            dn = (c >= 41);
            m  = (c - 1) / 4;
            if (m > MLIM) m = MLIM;
            pushExp("expiry", c, mk(m, !dn && (c % 4 == 0), 0, 0, dn, !dn, 0, dn));
        end
        for (int c = 1; c <= 46; c++) begin
            step();
            start = (c == 43);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        start = 1'b0;
    endtask

    // Quiz countdown with one expiry pulse, start ignored in PAUSE, then resume.
    task automatic test_quiz();
        expT e;
        int  q;
        applyReset();
        start = 1'b1;
        step();
        start = 1'b0;
        pause = 1'b1;
        for (int c = 2; c <= 14; c++) begin
            q = (c < 5) ? 2 : ((c < 9) ? 1 : 0);
            pushExp("quiz", c, mk(0, c % 4 == 0, q, c == 9, 0, 0, 1, 0));
        end
        pushExp("quiz_resume", 15, mk(0, 0, 0, 0, 0, 1, 0, 0));
        pushExp("quiz_resume", 16, mk(0, 1, 0, 0, 0, 1, 0, 0));
        pushExp("quiz_resume", 17, mk(1, 0, 0, 0, 0, 1, 0, 0));
        for (int c = 2; c <= 17; c++) begin
            step();
            start = (c == 6);
            pause = (c <= 13);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    // Pause raised on a tick cycle still counts that tick; start ignored in RUN.
    task automatic test_pause_on_tick();
        expT e;
        applyReset();
        start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            pushExp("pause_tick_run", c, mk((c - 1) / 4, c % 4 == 0, 0, 0, 0, 1, 0, 0));
        end
        pushExp("pause_tick", 21, mk(5, 0, 2, 0, 0, 0, 1, 0));
        pushExp("pause_tick", 22, mk(5, 0, 2, 0, 0, 0, 1, 0));
        pushExp("pause_drop", 23, mk(5, 0, 0, 0, 0, 1, 0, 0));
        for (int c = 1; c <= 23; c++) begin
            step();
            start = (c == 10);
            pause = (c == 20) || (c == 21);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    // Freeze on a tick discards it; clear returns to IDLE with counters zeroed.
    task automatic test_freeze_tick();
        expT e;
        applyReset();
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            pushExp("freeze_run", c, mk((c - 1) / 4, c % 4 == 0, 0, 0, 0, 1, 0, 0));
        end
        for (int c = 13; c <= 15; c++) begin
            pushExp("freeze_done", c, mk(2, 0, 0, 0, 0, 0, 0, 1));
        end
        pushExp("clear_idle", 16, mk(0, 0, 0, 0, 0, 0, 0, 0));
        pushExp("clear_idle", 17, mk(0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 1; c <= 17; c++) begin
            step();
            freeze = (c == 12);
            start  = (c == 14);
            clear  = (c == 15);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        freeze = 1'b0; start = 1'b0; clear = 1'b0;
    endtask

    // Asynchronous reset mid-PAUSE; afterwards the timer must wait for start.
    task automatic test_async_reset();
        expT e;
        applyReset();
        start = 1'b1;
        for (int c = 1; c <= 29; c++) begin
            pushExp("pre_reset_run", c, mk((c - 1) / 4, c % 4 == 0, 0, 0, 0, 1, 0, 0));
        end
        pushExp("pre_reset_pause", 30, mk(7, 0, 2, 0, 0, 0, 1, 0));
        for (int c = 1; c <= 30; c++) begin
            step();
            start = 1'b0;
            pause = (c >= 29);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        #2;
        Reset_n = 1'b0;
        pushExp("async_reset", 30, mk(0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        e = expQ.pop_front();
        checks++;
        if (obsVec() !== e.v) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
        end
        #1;
        Reset_n = 1'b1;
        pause   = 1'b0;
        pushExp("idle_after_reset", 31, mk(0, 0, 0, 0, 0, 0, 0, 0));
        pushExp("idle_after_reset", 32, mk(0, 0, 0, 0, 0, 0, 0, 0));
        pushExp("restart", 33, mk(0, 0, 0, 0, 0, 1, 0, 0));
        for (int c = 31; c <= 33; c++) begin
            step();
            start = (c == 32);
            e = expQ.pop_front();
            checks++;
            if (obsVec() !== e.v) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: got %b required %b", e.name, e.cyc, obsVec(), e.v);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_expiry();
        test_quiz();
        test_pause_on_tick();
        test_freeze_tick();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
